repair_alloc: RTL and testbench
===============================

REPAIR_ALLOC -- requirements
Module: repair_alloc

Interface
REQ-001 SHALL have parameter NENT, default 8, meaning number of spare remap entries (power of two, 2..32).
REQ-002 SHALL have parameter AW, default 16, meaning fault/lookup address width ({select[5:0], addr[9:0]}).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port BIST_EN  input  1  test session active; a 0->1 edge starts a session.
REQ-006 SHALL have port BIST_DONE  input  1  one-cycle pulse marking the end of BIST fault reporting.
REQ-007 SHALL have port FAIL_VALID  input  1  a fault address is offered.
REQ-008 SHALL have port FAIL_ADDR  input  AW  the failing main-array address.
REQ-009 SHALL have port FAIL_READY  output  1  the fault is accepted in the cycle where FAIL_VALID and FAIL_READY are both 1.
REQ-010 SHALL have port LK_VALID  input  1  a host lookup request.
REQ-011 SHALL have port LK_ADDR  input  AW  the host address to be checked against the remap table.
REQ-012 SHALL have port LK_HIT  output  1  the registered lookup result: the address is remapped.
REQ-013 SHALL have port LK_IDX  output  $clog2(NENT)  the spare entry index for a hit; 0 on a miss.
REQ-014 SHALL have port REPAIR_CNT  output  $clog2(NENT+1)  the number of allocated entries.
REQ-015 SHALL have port REPAIR_OK  output  1  the session has ended and all faults are remapped.
REQ-016 SHALL have port REPAIR_FAIL  output  1  more faults arrived than there are entries (unrepairable).

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, DONE, OVF.
REQ-018 In IDLE or DONE, a BIST_EN 0->1 edge SHALL clear all entry valid bits and REPAIR_CNT, and the next state SHALL be COLLECT.
REQ-019 In OVF, a BIST_EN 0->1 edge SHALL clear all entry valid bits and REPAIR_CNT, and the next state SHALL be COLLECT.
REQ-020 FAIL_READY SHALL be 1 only in COLLECT.
REQ-021 An accepted fault SHALL be written to entry REPAIR_CNT, and REPAIR_CNT SHALL increment, both effective the next cycle.
REQ-022 A fault accepted when REPAIR_CNT==NENT SHALL NOT be stored, and the next state SHALL be OVF.
REQ-023 In COLLECT, when BIST_DONE is 1 the next state SHALL be DONE.
REQ-024 If BIST_DONE and an accepted fault coincide, the fault SHALL be processed first; if that fault overflows, OVF SHALL win over DONE.
REQ-025 BIST_EN falling to 0 in COLLECT without BIST_DONE SHALL move the FSM to IDLE and keep the table contents.
REQ-026 REPAIR_OK SHALL be 1 exactly when the state is DONE.
REQ-027 REPAIR_FAIL SHALL be 1 exactly when the state is OVF.
REQ-028 Lookup SHALL have 1-cycle latency: LK_HIT/LK_IDX are registered from the LK_VALID/LK_ADDR of the previous cycle.
REQ-029 LK_HIT SHALL be 1 only if LK_VALID was 1, the state was DONE, and a valid entry equals LK_ADDR.
REQ-030 On multiple matching entries, the lowest index SHALL win.
REQ-031 LK_HIT SHALL be 0 and LK_IDX SHALL be 0 when there is no hit.

Reset
REQ-032 While RSTN==0 at a clock edge: state SHALL be IDLE; all entry valid bits SHALL be 0; REPAIR_CNT, LK_HIT, LK_IDX, REPAIR_OK and REPAIR_FAIL SHALL be 0; FAIL_READY SHALL be 0; the stored BIST_EN edge-detect flop SHALL be 0.
REQ-033 Reset asserted mid-session SHALL abandon the session; no partial table SHALL survive.

Configuration
REQ-034 With macro REPAIR_ALLOC_DEDUP_EN defined, an accepted fault whose address equals a valid entry (or the entry being written that cycle) SHALL be dropped without incrementing REPAIR_CNT or causing OVF.
REQ-035 Without REPAIR_ALLOC_DEDUP_EN, every accepted fault SHALL consume an entry, duplicates included.

Structure
REQ-036 A shared package repair_pkg SHALL hold the FSM state enum, default NENT/AW, and the address field widths (SEL_W=6, ROW_W=10).
REQ-037 One sub-module repair_cam SHALL hold the entry registers plus the match/priority-encode logic; it SHALL be instantiated once and shared by lookup and dedup compare.

Verification
REQ-038 Scenario: reset, BIST_EN rises, faults 0x0123 and 0x8001 accepted, BIST_DONE -> REPAIR_CNT=2, REPAIR_OK=1; lookup 0x8001 gives LK_HIT=1, LK_IDX=1 one cycle later.
REQ-039 Scenario: NENT=8, 9 distinct faults -> 9th accepted, REPAIR_CNT stays 8, REPAIR_FAIL=1, lookups give LK_HIT=0.
REQ-040 Scenario: with DEDUP_EN, fault 0x0040 offered 3 times then BIST_DONE -> REPAIR_CNT=1; without DEDUP_EN -> REPAIR_CNT=3.
REQ-041 Scenario: 8th fault and BIST_DONE in the same cycle -> DONE, REPAIR_CNT=8; 9th fault with BIST_DONE in the same cycle -> OVF.
REQ-042 Scenario: RSTN low for one cycle after 3 faults -> REPAIR_CNT=0, lookup 0x0123 gives LK_HIT=0, state IDLE.
REQ-043 Scenario: second session after DONE with new fault 0x0200 -> old entries cleared, lookup 0x0123 misses, lookup 0x0200 hits at LK_IDX=0.

Source files
------------

// File: rtl/repair_pkg.sv
// repair_pkg: shared FSM states, default sizes and address field widths for repair_alloc
package repair_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE, OVF} state_e;
  localparam int SEL_W = 6;
  localparam int ROW_W = 10;
  localparam int NENT_DEF = 8;
  localparam int AW_DEF = SEL_W + ROW_W;
endpackage

// File: rtl/repair_cam.sv
// repair_cam: spare remap entry registers with lowest-index address match encoder
module repair_cam #(
  parameter int NENT = 8,
  parameter int AW = 16
) (
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [$clog2(NENT)-1:0] widx_i,
  input  logic [AW-1:0]           wdata_i,
  input  logic [AW-1:0]           cmp_i,
  output logic                    hit_o,
  output logic [$clog2(NENT)-1:0] idx_o
);
  localparam int IW = $clog2(NENT);
  logic [AW-1:0] addr_q [NENT];
  logic [NENT-1:0] vld_q;
  always_ff @(posedge clk)
    if (clr_i) vld_q <= '0;
    else if (we_i) begin
      vld_q[widx_i] <= 1'b1;
      addr_q[widx_i] <= wdata_i;
    end
  // scanning downward lets the lowest matching index overwrite the rest
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NENT - 1; i >= 0; i--)
      if (vld_q[i] && addr_q[i] == cmp_i) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
  end
endmodule

// File: rtl/repair_alloc.sv
// repair_alloc: collects BIST fault addresses into spare remap entries and serves host lookups
// Optional REPAIR_ALLOC_DEDUP_EN drops faults already present in the table.
module repair_alloc
  import repair_pkg::*;
#(
  parameter int NENT = NENT_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      BIST_EN,
  input  logic                      BIST_DONE,
  input  logic                      FAIL_VALID,
  input  logic [AW-1:0]             FAIL_ADDR,
  output logic                      FAIL_READY,
  input  logic                      LK_VALID,
  input  logic [AW-1:0]             LK_ADDR,
  output logic                      LK_HIT,
  output logic [$clog2(NENT)-1:0]   LK_IDX,
  output logic [$clog2(NENT+1)-1:0] REPAIR_CNT,
  output logic                      REPAIR_OK,
  output logic                      REPAIR_FAIL
);
  localparam int IW = $clog2(NENT);
  localparam int CW = $clog2(NENT + 1);
  state_e state_q;
  logic en_q, lk_hit_q;
  logic [IW-1:0] lk_idx_q;
  logic [CW-1:0] cnt_q;
  logic cam_hit, dup, rise, acc, take, full, wr, clr, lk_now;
  logic [IW-1:0] cam_idx;
  assign rise = BIST_EN & ~en_q;
  assign acc = FAIL_VALID & FAIL_READY;
`ifdef REPAIR_ALLOC_DEDUP_EN
  assign dup = cam_hit;
`else
  assign dup = 1'b0;
`endif
  assign take = acc & ~dup;
  assign full = cnt_q == CW'(NENT);
  assign wr = take & ~full;
  assign clr = ~RSTN | (rise & (state_q != COLLECT));
  assign lk_now = LK_VALID & (state_q == DONE) & cam_hit;
  // one comparator bank: faults use it while collecting, lookups otherwise
  repair_cam #(.NENT(NENT), .AW(AW)) u_cam (
    .clk(CLK),
    .clr_i(clr),
    .we_i(wr),
    .widx_i(cnt_q[IW-1:0]),
    .wdata_i(FAIL_ADDR),
    .cmp_i(state_q == COLLECT ? FAIL_ADDR : LK_ADDR),
    .hit_o(cam_hit),
    .idx_o(cam_idx)
  );
  always_ff @(posedge CLK)
    if (!RSTN) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      cnt_q <= '0;
      lk_hit_q <= 1'b0;
      lk_idx_q <= '0;
    end else begin
      en_q <= BIST_EN;
      lk_hit_q <= lk_now;
      lk_idx_q <= lk_now ? cam_idx : '0;
      if (state_q == COLLECT) begin
        if (wr) cnt_q <= cnt_q + CW'(1);
        state_q <= (take && full) ? OVF : BIST_DONE ? DONE : !BIST_EN ? IDLE : COLLECT;
      end else if (rise) begin
        cnt_q <= '0;
        state_q <= COLLECT;
      end
    end
  assign FAIL_READY = state_q == COLLECT;
  assign REPAIR_OK = state_q == DONE;
  assign REPAIR_FAIL = state_q == OVF;
  assign REPAIR_CNT = cnt_q;
  assign LK_HIT = lk_hit_q;
  assign LK_IDX = lk_idx_q;
endmodule

// File: tb/tb_repair_alloc.sv
// tb_repair_alloc: directed scenarios plus random traffic checked against a queue-based table model
module tb_repair_alloc;
  localparam int NENT = 8;
  localparam int AW = 16;
`ifdef REPAIR_ALLOC_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  localparam int S_IDLE = 0, S_COL = 1, S_DONE = 2, S_OVF = 3;
  logic CLK = 1'b0, RSTN = 1'b0, BIST_EN = 1'b0, BIST_DONE = 1'b0;
  logic FAIL_VALID = 1'b0, LK_VALID = 1'b0;
  logic [AW-1:0] FAIL_ADDR = '0, LK_ADDR = '0;
  logic FAIL_READY, LK_HIT, REPAIR_OK, REPAIR_FAIL;
  logic [2:0] LK_IDX;
  logic [3:0] REPAIR_CNT;
  int n_vec = 0, n_err = 0;
  int m_st = S_IDLE, m_hit = 0, m_idx = 0;
  bit m_en = 1'b0;
  logic [AW-1:0] m_tab[$];
  logic [AW-1:0] pool[12];

  repair_alloc #(.NENT(NENT), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .BIST_EN(BIST_EN), .BIST_DONE(BIST_DONE),
    .FAIL_VALID(FAIL_VALID), .FAIL_ADDR(FAIL_ADDR), .FAIL_READY(FAIL_READY),
    .LK_VALID(LK_VALID), .LK_ADDR(LK_ADDR), .LK_HIT(LK_HIT), .LK_IDX(LK_IDX),
    .REPAIR_CNT(REPAIR_CNT), .REPAIR_OK(REPAIR_OK), .REPAIR_FAIL(REPAIR_FAIL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_addr(input logic [AW-1:0] a);
    for (int i = 0; i < m_tab.size(); i++)
      if (m_tab[i] == a) return i;
    return -1;
  endfunction

  task automatic model_step();
    int f;
    if (!RSTN) begin
      m_st = S_IDLE; m_tab.delete(); m_en = 1'b0; m_hit = 0; m_idx = 0;
      return;
    end
    f = (LK_VALID && m_st == S_DONE) ? find_addr(LK_ADDR) : -1;
    m_hit = f >= 0;
    m_idx = f >= 0 ? f : 0;
    if (m_st == S_COL) begin
      int ns = S_COL;
      if (FAIL_VALID && !(DEDUP && find_addr(FAIL_ADDR) >= 0)) begin
        if (m_tab.size() < NENT) m_tab.push_back(FAIL_ADDR);
        else ns = S_OVF;
      end
      if (ns != S_OVF) ns = BIST_DONE ? S_DONE : !BIST_EN ? S_IDLE : S_COL;
      m_st = ns;
    end else if (BIST_EN && !m_en) begin
      m_tab.delete();
      m_st = S_COL;
    end
    m_en = BIST_EN;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("fail_ready", FAIL_READY, m_st == S_COL);
    chk("repair_ok", REPAIR_OK, m_st == S_DONE);
    chk("repair_fail", REPAIR_FAIL, m_st == S_OVF);
    chk("repair_cnt", REPAIR_CNT, m_tab.size());
    chk("lk_hit", LK_HIT, m_hit);
    chk("lk_idx", LK_IDX, m_idx);
  endtask

  task automatic quiet();
    FAIL_VALID = 1'b0; BIST_DONE = 1'b0; LK_VALID = 1'b0;
  endtask

  task automatic start();
    quiet(); BIST_EN = 1'b0; cyc(); BIST_EN = 1'b1; cyc();
  endtask

  task automatic fault(input logic [AW-1:0] a, input logic d);
    FAIL_VALID = 1'b1; FAIL_ADDR = a; BIST_DONE = d; cyc(); quiet();
  endtask

  task automatic finish_bist();
    BIST_DONE = 1'b1; cyc(); quiet();
  endtask

  task automatic look(input logic [AW-1:0] a);
    LK_VALID = 1'b1; LK_ADDR = a; cyc(); quiet();
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_cnt", REPAIR_CNT, 0);
    chk("rst_ready", FAIL_READY, 0);
    RSTN = 1'b1;
    start();
    fault(16'h0123, 1'b0);
    fault(16'h8001, 1'b0);
    finish_bist();
    chk("s1_cnt", REPAIR_CNT, 2);
    chk("s1_ok", REPAIR_OK, 1);
    look(16'h8001);
    chk("s1_hit", LK_HIT, 1);
    chk("s1_idx", LK_IDX, 1);
    look(16'h0123);
    chk("s1_idx0", LK_IDX, 0);
    look(16'h0555);
    chk("s1_miss", LK_HIT, 0);
    start();
    repeat (3) fault(16'h0040, 1'b0);
    finish_bist();
    chk("dup_cnt", REPAIR_CNT, DEDUP ? 1 : 3);
    look(16'h0040);
    chk("dup_lowidx", LK_IDX, 0);
    start();
    for (int i = 0; i < 7; i++) fault(16'h1000 + 16'(i), 1'b0);
    fault(16'h1007, 1'b1);
    chk("edge_done_ok", REPAIR_OK, 1);
    chk("edge_done_cnt", REPAIR_CNT, 8);
    start();
    for (int i = 0; i < 8; i++) fault(16'h2000 + 16'(i), 1'b0);
    fault(16'h2008, 1'b1);
    chk("edge_ovf_fail", REPAIR_FAIL, 1);
    chk("edge_ovf_ok", REPAIR_OK, 0);
    start();
    for (int i = 0; i < 9; i++) fault(16'h3000 + 16'(i), 1'b0);
    chk("ovf_fail", REPAIR_FAIL, 1);
    chk("ovf_cnt", REPAIR_CNT, 8);
    look(16'h3000);
    chk("ovf_lk", LK_HIT, 0);
    start();
    fault(16'h0123, 1'b0);
    fault(16'h0124, 1'b0);
    fault(16'h0125, 1'b0);
    RSTN = 1'b0; cyc(); RSTN = 1'b1;
    chk("rst_mid_cnt", REPAIR_CNT, 0);
    chk("rst_mid_ready", FAIL_READY, 0);
    start();
    finish_bist();
    look(16'h0123);
    chk("rst_mid_lk", LK_HIT, 0);
    start();
    fault(16'h0123, 1'b0);
    finish_bist();
    start();
    fault(16'h0200, 1'b0);
    finish_bist();
    look(16'h0123);
    chk("s2_old_miss", LK_HIT, 0);
    look(16'h0200);
    chk("s2_new_hit", LK_HIT, 1);
    chk("s2_new_idx", LK_IDX, 0);
    for (int i = 0; i < 12; i++) pool[i] = AW'($urandom);
    for (int n = 0; n < 600; n++) begin
      RSTN = $urandom_range(0, 59) != 0;
      if ($urandom_range(0, 11) == 0) BIST_EN = ~BIST_EN;
      BIST_DONE = $urandom_range(0, 14) == 0;
      FAIL_VALID = $urandom_range(0, 1) == 1;
      FAIL_ADDR = pool[$urandom_range(0, 11)];
      LK_VALID = $urandom_range(0, 1) == 1;
      LK_ADDR = pool[$urandom_range(0, 11)];
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
